// File: rtl/imem_arb_pkg.sv
// ---------------------------------------------------------------------------
// imem_arb_pkg
// Shared types and constants for the instruction-ROM arbiter.
//   grant_e       : which requester owns the ROM this cycle
//   ROM_DEPTH_DEF : default number of ROM words
//   ADDR_W        : byte address width
//   WORD_OFS      : byte-to-word shift (32-bit words)
//   WAIT_W        : width of the data-port aging counter (holds 0..15)
//   addrBad()     : misaligned or beyond-the-ROM address test
// ---------------------------------------------------------------------------
package imem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    localparam int ROM_DEPTH_DEF = 256;
    localparam int ADDR_W        = 32;
    localparam int WORD_OFS      = 2;
    localparam int WAIT_W        = 4;

    // A request is bad when it is not word aligned or its word index falls
    // past the last ROM word.
    function automatic logic addrBad(input logic [ADDR_W-1:0] addr, input int depth);
        logic [ADDR_W-1:0] wordIdx;
        wordIdx = addr >> WORD_OFS;
        return (addr[WORD_OFS-1:0] != '0) || (wordIdx >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if
// Bundles both requester handshakes, their response channels and the ROM
// read port of the instruction-ROM arbiter.
//   master modport : requester/ROM side (drives requests and rom_data)
//   slave modport  : arbiter side (drives readies, responses and rom_addr)
// ---------------------------------------------------------------------------
interface imem_arbiter_if
    import imem_arb_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_flush;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    logic              i_resp_err;

    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              d_resp_err;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  i_req_valid, i_req_addr, i_flush, d_req_valid, d_req_addr, rom_data,
        output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        output d_req_ready, d_resp_valid, d_resp_data, d_resp_err, rom_addr
    );

    modport master (
        output i_req_valid, i_req_addr, i_flush, d_req_valid, d_req_addr, rom_data,
        input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err, rom_addr
    );

endinterface

// File: rtl/imem_arb_sel.sv
// ---------------------------------------------------------------------------
// imem_arb_sel
// Combinational grant selector for the instruction-ROM arbiter.
// Fetch normally wins, but a data request that has already lost MAX_WAIT
// cycles in a row is granted ahead of fetch.
//   iReqValid_i : fetch request pending
//   dReqValid_i : data request pending
//   iFlush_i    : fetch traffic is being killed this cycle
//   waitCnt_i   : consecutive cycles the data port has lost
//   grant_o     : owner of the ROM this cycle
// ---------------------------------------------------------------------------
module imem_arb_sel
    import imem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              iReqValid_i,
    input  logic              dReqValid_i,
    input  logic              iFlush_i,
    input  logic [WAIT_W-1:0] waitCnt_i,
    output grant_e            grant_o
);

    // Starved data port first, then unflushed fetch, then data.
    always_comb begin
        grant_o = GNT_NONE;
        if (dReqValid_i && (waitCnt_i == WAIT_W'(MAX_WAIT))) begin
            grant_o = GNT_D;
        end else if (iReqValid_i && !iFlush_i) begin
            grant_o = GNT_I;
        end else if (dReqValid_i) begin
            grant_o = GNT_D;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Shares one combinational-read instruction ROM between the fetch port (I)
// and the data-side constant/debug port (D). One request is accepted per
// cycle and its ROM word is returned exactly one cycle later on the owning
// port. An aging counter keeps the data port from starving behind fetch.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : imem_arbiter_if.slave (request/response handshakes, ROM port)
// Parameters: DEPTH (ROM words), MAX_WAIT (1..15 losses before D is forced),
//             DATA_W (ROM word width).
// Optional build macro IMEM_ARB_RANGE_CHK_EN: misaligned or out-of-range
// requests are flagged through resp_err with zero data, and the ROM sees
// address 0 for them. Without it resp_err is tied low and addresses pass
// to the ROM unchanged.
// ---------------------------------------------------------------------------
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH    = ROM_DEPTH_DEF,
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_arbiter_if.slave bus
);

    // Parameter sanity, caught while elaborating.
    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : gBadMaxWait
        $error("imem_arbiter: MAX_WAIT must be in 1..15");
    end
    if (DEPTH < 1) begin : gBadDepth
        $error("imem_arbiter: DEPTH must be positive");
    end

    grant_e            grant;
    grant_e            grant_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [WAIT_W-1:0] waitCnt_d;
    logic [ADDR_W-1:0] selAddr;
    logic              selBad;
    logic [DATA_W-1:0] iRespData_q;
    logic [DATA_W-1:0] dRespData_q;

    imem_arb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) uSel (
        .iReqValid_i (bus.i_req_valid),
        .dReqValid_i (bus.d_req_valid),
        .iFlush_i    (bus.i_flush),
        .waitCnt_i   (waitCnt_q),
        .grant_o     (grant)
    );

    // Route the winning port's address toward the ROM; idle cycles read 0.
    always_comb begin
        selAddr = '0;
        unique case (grant)
            GNT_I:   selAddr = bus.i_req_addr;
            GNT_D:   selAddr = bus.d_req_addr;
            default: selAddr = '0;
        endcase
    end

`ifdef IMEM_ARB_RANGE_CHK_EN
    assign selBad = (grant != GNT_NONE) && addrBad(selAddr, DEPTH);
`else
    assign selBad = 1'b0;
`endif

    assign bus.rom_addr    = selBad ? '0 : selAddr;
    assign bus.i_req_ready = (grant == GNT_I);
    assign bus.d_req_ready = (grant == GNT_D);

    // The data port ages only while it is actually waiting; any grant or a
    // withdrawn request starts the count over.
    always_comb begin
        waitCnt_d = '0;
        if (bus.d_req_valid && (grant != GNT_D)) begin
            waitCnt_d = (waitCnt_q == WAIT_W'(MAX_WAIT)) ? waitCnt_q : waitCnt_q + 1'b1;
        end
    end

    // Last cycle's grant doubles as the response-valid state, so a reset
    // drops any in-flight response immediately. Data registers only load
    // for the port that won, and otherwise hold their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= GNT_NONE;
            waitCnt_q   <= '0;
            iRespData_q <= '0;
            dRespData_q <= '0;
        end else begin
            grant_q   <= grant;
            waitCnt_q <= waitCnt_d;
            if (grant == GNT_I) begin
                iRespData_q <= selBad ? '0 : bus.rom_data;
            end
            if (grant == GNT_D) begin
                dRespData_q <= selBad ? '0 : bus.rom_data;
            end
        end
    end

`ifdef IMEM_ARB_RANGE_CHK_EN
    logic iRespErr_q;
    logic dRespErr_q;

    // Error flags travel with the data of the same accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iRespErr_q <= 1'b0;
            dRespErr_q <= 1'b0;
        end else begin
            if (grant == GNT_I) begin
                iRespErr_q <= selBad;
            end
            if (grant == GNT_D) begin
                dRespErr_q <= selBad;
            end
        end
    end

    assign bus.i_resp_err = (grant_q == GNT_I) && iRespErr_q;
    assign bus.d_resp_err = (grant_q == GNT_D) && dRespErr_q;
`else
    assign bus.i_resp_err = 1'b0;
    assign bus.d_resp_err = 1'b0;
`endif

    assign bus.i_resp_valid = (grant_q == GNT_I);
    assign bus.d_resp_valid = (grant_q == GNT_D);
    assign bus.i_resp_data  = iRespData_q;
    assign bus.d_resp_data  = dRespData_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
// Self-checking bench for imem_arbiter. The ROM returns {16'hC0DE, addr[17:2]}.
// Every accepted request pushes its expected response onto a per-port queue;
// a free-running monitor pops and compares whenever responses are due.
// Directed scenarios are followed by a randomized request/flush mix.
// Honours IMEM_ARB_RANGE_CHK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 256;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cycleCnt;
    int   tests;
    int   fails;
    int   dLosses;

    exp_t        iExpQ[$];
    exp_t        dExpQ[$];
    logic [31:0] lastIData;
    logic [31:0] lastDData;

    imem_arbiter_if #(.DATA_W(32)) bus ();

    imem_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT),
        .DATA_W   (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock and free-running cycle counter used to time responses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural ROM.
    assign bus.rom_data = {16'hC0DE, bus.rom_addr[17:2]};

    // Comparison helper shared by every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Bad-request rule expressed as plain word arithmetic.
    function automatic logic isBad(input logic [31:0] a);
`ifdef IMEM_ARB_RANGE_CHK_EN
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] romWord(input logic [31:0] a);
        return isBad(a) ? 32'h0 : {16'hC0DE, a[17:2]};
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
`ifdef IMEM_ARB_RANGE_CHK_EN
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        else if ($urandom_range(0, 7) == 0) a = a + 32'h400 * 32'($urandom_range(1, 1000));
`endif
        return a;
    endfunction

    // Drive one cycle of requests just after the rising edge, then at the
    // falling edge decide who should win: a data port that has lost MAX_WAIT
    // times in a row wins, else an unflushed fetch, else data. Readies and
    // the ROM address are checked and the expected response is queued.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic fl,
                                 input logic dv, input logic [31:0] da, output int gnt);
        logic [31:0] expRom;
        exp_t        e;
        @(posedge clk);
        #1;
        bus.i_req_valid = iv;
        bus.i_req_addr  = ia;
        bus.i_flush     = fl;
        bus.d_req_valid = dv;
        bus.d_req_addr  = da;
        @(negedge clk);
        if (dv && dLosses >= MAX_WAIT) gnt = 2;
        else if (iv && !fl)            gnt = 1;
        else if (dv)                   gnt = 2;
        else                           gnt = 0;
        if (dv && gnt != 2) dLosses = (dLosses < MAX_WAIT) ? dLosses + 1 : MAX_WAIT;
        else                dLosses = 0;
        checkOutput("i_req_ready", 32'(bus.i_req_ready), 32'(gnt == 1));
        checkOutput("d_req_ready", 32'(bus.d_req_ready), 32'(gnt == 2));
        expRom = 32'h0;
        if (gnt == 1) expRom = isBad(ia) ? 32'h0 : ia;
        if (gnt == 2) expRom = isBad(da) ? 32'h0 : da;
        checkOutput("rom_addr", bus.rom_addr, expRom);
        e.cyc = cycleCnt + 1;
        if (gnt == 1) begin
            e.data = romWord(ia);
            e.err  = isBad(ia);
            iExpQ.push_back(e);
        end
        if (gnt == 2) begin
            e.data = romWord(da);
            e.err  = isBad(da);
            dExpQ.push_back(e);
        end
    endtask

    // Monitor: every falling edge out of reset, each port's response valid
    // must match whether a queued response is due now; due responses are
    // compared, and idle data must hold the last delivered word.
    initial begin
        exp_t e;
        logic expV;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                expV = (iExpQ.size() > 0) && (iExpQ[0].cyc == cycleCnt);
                checkOutput("i_resp_valid", 32'(bus.i_resp_valid), 32'(expV));
                if (expV) begin
                    e = iExpQ.pop_front();
                    if (bus.i_resp_valid) begin
                        checkOutput("i_resp_data", bus.i_resp_data, e.data);
                        checkOutput("i_resp_err", 32'(bus.i_resp_err), 32'(e.err));
                    end
                    lastIData = e.data;
                end else begin
                    checkOutput("i_resp_hold", bus.i_resp_data, lastIData);
                end

                expV = (dExpQ.size() > 0) && (dExpQ[0].cyc == cycleCnt);
                checkOutput("d_resp_valid", 32'(bus.d_resp_valid), 32'(expV));
                if (expV) begin
                    e = dExpQ.pop_front();
                    if (bus.d_resp_valid) begin
                        checkOutput("d_resp_data", bus.d_resp_data, e.data);
                        checkOutput("d_resp_err", 32'(bus.d_resp_err), 32'(e.err));
                    end
                    lastDData = e.data;
                end else begin
                    checkOutput("d_resp_hold", bus.d_resp_data, lastDData);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int          g;
        logic        iPend;
        logic        dPend;
        logic        fl;
        logic [31:0] iAddr;
        logic [31:0] dAddr;

        tests     = 0;
        fails     = 0;
        dLosses   = 0;
        lastIData = 32'h0;
        lastDData = 32'h0;
        reset_n   = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = 32'h0;
        bus.i_flush     = 1'b0;
        bus.d_req_valid = 1'b0;
        bus.d_req_addr  = 32'h0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_i_resp_valid", 32'(bus.i_resp_valid), 32'h0);
        checkOutput("rst_d_resp_valid", 32'(bus.d_resp_valid), 32'h0);
        checkOutput("rst_i_resp_data", bus.i_resp_data, 32'h0);
        checkOutput("rst_d_resp_data", bus.d_resp_data, 32'h0);
        checkOutput("rst_i_resp_err", 32'(bus.i_resp_err), 32'h0);
        checkOutput("rst_d_resp_err", 32'(bus.d_resp_err), 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Single fetch from 0x10.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, g);
        checkOutput("single_i_ready", 32'(bus.i_req_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
        checkOutput("single_i_valid", 32'(bus.i_resp_valid), 32'h1);
        checkOutput("single_i_data", bus.i_resp_data, 32'hC0DE0004);
        checkOutput("single_d_valid", 32'(bus.d_resp_valid), 32'h0);

        // Back-to-back fetches without bubbles.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, g);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, g);
        checkOutput("b2b_data0", bus.i_resp_data, 32'hC0DE0000);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, g);
        checkOutput("b2b_data1", bus.i_resp_data, 32'hC0DE0001);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
        checkOutput("b2b_valid2", 32'(bus.i_resp_valid), 32'h1);
        checkOutput("b2b_data2", bus.i_resp_data, 32'hC0DE0002);

        // Both ports held: data wins every fifth cycle.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'h20, g);
            checkOutput("aging_d_ready", 32'(bus.d_req_ready), 32'(k % 5 == 4));
            if (k == 5) begin
                checkOutput("aging_d_valid", 32'(bus.d_resp_valid), 32'h1);
                checkOutput("aging_d_data", bus.d_resp_data, 32'hC0DE0008);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);

        // Flush: fetch blocked, prior fetch response still shown, data granted.
        applyStimulus(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, g);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h20, g);
        checkOutput("flush_i_ready", 32'(bus.i_req_ready), 32'h0);
        checkOutput("flush_d_ready", 32'(bus.d_req_ready), 32'h1);
        checkOutput("flush_prior_valid", 32'(bus.i_resp_valid), 32'h1);
        checkOutput("flush_prior_data", bus.i_resp_data, 32'hC0DE000F);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
        checkOutput("flush_no_resp", 32'(bus.i_resp_valid), 32'h0);
        checkOutput("flush_d_valid", 32'(bus.d_resp_valid), 32'h1);

        // Reset in the cycle after an accept discards the response.
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, g);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.i_req_valid = 1'b0;
        iExpQ.delete();
        dExpQ.delete();
        dLosses   = 0;
        lastIData = 32'h0;
        lastDData = 32'h0;
        #1;
        checkOutput("rst_async_valid", 32'(bus.i_resp_valid), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
            checkOutput("rst_release_valid", 32'(bus.i_resp_valid), 32'h0);
        end

        // Range-check boundaries (ordinary data words in the default build).
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h402, g);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, g);
`ifdef IMEM_ARB_RANGE_CHK_EN
        checkOutput("rng_402_err", 32'(bus.d_resp_err), 32'h1);
        checkOutput("rng_402_data", bus.d_resp_data, 32'h0);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h3FC, g);
`ifdef IMEM_ARB_RANGE_CHK_EN
        checkOutput("rng_400_err", 32'(bus.d_resp_err), 32'h1);
        checkOutput("rng_400_data", bus.d_resp_data, 32'h0);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
        checkOutput("rng_3fc_err", 32'(bus.d_resp_err), 32'h0);
        checkOutput("rng_3fc_data", bus.d_resp_data, 32'hC0DE00FF);

        // Randomized traffic; requests are held until the model grants them.
        iPend = 1'b0;
        dPend = 1'b0;
        iAddr = 32'h0;
        dAddr = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if (!iPend && ($urandom_range(0, 3) != 0)) begin
                iPend = 1'b1;
                iAddr = randAddr();
            end
            if (!dPend && ($urandom_range(0, 1) == 0)) begin
                dPend = 1'b1;
                dAddr = randAddr();
            end
            fl = ($urandom_range(0, 7) == 0);
            applyStimulus(iPend, iAddr, fl, dPend, dAddr, g);
            if (g == 1) iPend = 1'b0;
            if (g == 2) dPend = 1'b0;
        end

        // Drain and confirm nothing expected went missing.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, g);
        end
        checkOutput("drain_i_queue", 32'(iExpQ.size()), 32'h0);
        checkOutput("drain_d_queue", 32'(dExpQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
